// File: rtl/apb_req_arbiter_pkg.sv
// Shared definitions for the two-requester APB arbiter: FSM encoding,
// bus widths and the default transfer timeout.
package apb_req_arbiter_pkg;

  localparam int ADDR_W             = 9;
  localparam int DATA_W             = 8;
  localparam int TIMEOUT_CYCLES_DEF = 15;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    XFER = 3'b010,
    DONE = 3'b100
  } state_t;

endpackage

// File: rtl/rr_sel2.sv
// Two-way round-robin selector: a lone request always wins, and on a tie
// the requester named by the priority pointer wins.
module rr_sel2
  import apb_req_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] win
);

  // One-hot winner selection
  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = ptr ? 2'b10 : 2'b01;
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Arbitrates two requesters onto a single APB bridge: latches the winner's
// command, watches the bus for completion, error or timeout, returns an ack.
module apb_req_arbiter
  import apb_req_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req0,
  input  logic              req1,
  input  logic              rw0,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic              ack0,
  output logic              ack1,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              transfer,
  output logic              READ_WRITE,
  output logic [ADDR_W-1:0] apb_write_paddr,
  output logic [ADDR_W-1:0] apb_read_paddr,
  output logic [DATA_W-1:0] apb_write_data,
  input  logic              PENABLE,
  input  logic              PREADY,
  input  logic              PSLVERR,
  input  logic [DATA_W-1:0] apb_read_data_out
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t            state_r, state_next_s;
  logic              armed_r;
  logic              ptr_r, ptr_next_s;
  logic [1:0]        gnt_r, gnt_next_s;
  logic [1:0]        ack_r, ack_next_s;
  logic              err_r, err_next_s;
  logic              xfer_r, xfer_next_s;
  logic              rw_r, rw_next_s;
  logic [ADDR_W-1:0] addr_r, addr_next_s;
  logic [DATA_W-1:0] wdata_r, wdata_next_s;
  logic [DATA_W-1:0] rdata_r, rdata_next_s;
  logic [7:0]        cnt_r, cnt_next_s;
  logic [1:0]        win_s;
  logic              sel_rw_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

  rr_sel2 u_sel (
    .req (({req1, req0})),
    .ptr (ptr_r),
    .win (win_s)
  );

  assign sel_rw_s    = win_s[1] ? rw1    : rw0;
  assign sel_addr_s  = win_s[1] ? addr1  : addr0;
  assign sel_wdata_s = win_s[1] ? wdata1 : wdata0;

  // Next-state and next-register computation
  always_comb begin
    state_next_s = state_r;
    ptr_next_s   = ptr_r;
    gnt_next_s   = gnt_r;
    ack_next_s   = 2'b00;
    err_next_s   = 1'b0;
    xfer_next_s  = 1'b0;
    rw_next_s    = rw_r;
    addr_next_s  = addr_r;
    wdata_next_s = wdata_r;
    rdata_next_s = rdata_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      IDLE: begin
        // armed_r holds off arbitration for the first edge after reset release
        if (armed_r && (win_s != 2'b00)) begin
          state_next_s = XFER;
          gnt_next_s   = win_s;
          ptr_next_s   = win_s[0];
          rw_next_s    = sel_rw_s;
          addr_next_s  = sel_addr_s;
          wdata_next_s = sel_rw_s ? {DATA_W{1'b0}} : sel_wdata_s;
          cnt_next_s   = 8'd0;
          xfer_next_s  = 1'b1;
        end else begin
          gnt_next_s   = 2'b00;
        end
      end
      XFER: begin
        if (PSLVERR) begin
          state_next_s = DONE;
          ack_next_s   = gnt_r;
          err_next_s   = 1'b1;
          gnt_next_s   = 2'b00;
        end else if (PENABLE && PREADY) begin
          state_next_s = DONE;
          ack_next_s   = gnt_r;
          gnt_next_s   = 2'b00;
          rdata_next_s = rw_r ? apb_read_data_out : rdata_r;
        end else if (cnt_r == CNT_LAST) begin
          state_next_s = DONE;
          ack_next_s   = gnt_r;
          err_next_s   = 1'b1;
          gnt_next_s   = 2'b00;
        end else begin
          xfer_next_s  = 1'b1;
          cnt_next_s   = cnt_r + 8'd1;
        end
      end
      DONE: begin
        state_next_s = IDLE;
        gnt_next_s   = 2'b00;
      end
      default: begin
        state_next_s = IDLE;
        gnt_next_s   = 2'b00;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Command, status and output registers
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      armed_r <= 1'b0;
      ptr_r   <= 1'b0;
      gnt_r   <= 2'b00;
      ack_r   <= 2'b00;
      err_r   <= 1'b0;
      xfer_r  <= 1'b0;
      rw_r    <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      rdata_r <= {DATA_W{1'b0}};
      cnt_r   <= 8'd0;
    end else begin
      armed_r <= 1'b1;
      ptr_r   <= ptr_next_s;
      gnt_r   <= gnt_next_s;
      ack_r   <= ack_next_s;
      err_r   <= err_next_s;
      xfer_r  <= xfer_next_s;
      rw_r    <= rw_next_s;
      addr_r  <= addr_next_s;
      wdata_r <= wdata_next_s;
      rdata_r <= rdata_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  assign gnt             = gnt_r;
  assign ack0            = ack_r[0];
  assign ack1            = ack_r[1];
  assign err             = err_r;
  assign transfer        = xfer_r;
  assign READ_WRITE      = rw_r;
  assign apb_write_paddr = addr_r;
  assign apb_read_paddr  = addr_r;
  assign apb_write_data  = wdata_r;
  assign rdata           = rdata_r;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: a simple bridge/slave model plus a
// transaction-level reference of grant order, latency, ack/err and read data.
module tb_apb_req_arbiter;

  localparam int TO = 15;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       req0, req1, rw0, rw1;
  logic [8:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic [1:0] gnt;
  logic       ack0, ack1, err, transfer, READ_WRITE;
  logic [7:0] rdata, apb_write_data, rd_data;
  logic [8:0] apb_write_paddr, apb_read_paddr;
  logic       PENABLE, PREADY, PSLVERR;

  int  ws;          // wait states: PREADY low for ws PENABLE cycles
  bit  slv;         // slave answers with an error
  int  xc;          // cycles transfer has already been high
  int  passed, total;
  bit  ptr_m;       // reference priority pointer
  logic [7:0] exp_rdata;
  int  last_win, last_wait;

  apb_req_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata),
    .transfer(transfer), .READ_WRITE(READ_WRITE),
    .apb_write_paddr(apb_write_paddr), .apb_read_paddr(apb_read_paddr),
    .apb_write_data(apb_write_data),
    .PENABLE(PENABLE), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .apb_read_data_out(rd_data)
  );

  always #5 PCLK = ~PCLK;

  // Bridge model: setup phase on the 2nd transfer cycle, access from the 3rd
  always @(posedge PCLK) xc <= transfer ? xc + 1 : 0;
  assign PENABLE = transfer && (xc >= 2);
  assign PREADY  = PENABLE && (xc >= 2 + ws);
  assign PSLVERR = PREADY && slv;

  task automatic do_txn(input bit drop, input bit mutate);
    int w, cyc, exp_cyc;
    bit exp_err, erw;
    logic [8:0] ea;
    logic [7:0] ewd;
    logic [1:0] eg;
    w   = (req0 && req1) ? (ptr_m ? 1 : 0) : (req1 ? 1 : 0);
    erw = (w == 1) ? rw1 : rw0;
    ea  = (w == 1) ? addr1 : addr0;
    ewd = erw ? 8'h00 : ((w == 1) ? wdata1 : wdata0);
    eg  = (w == 1) ? 2'b10 : 2'b01;
    if (3 + ws <= TO) begin exp_cyc = 3 + ws; exp_err = slv; end
    else begin exp_cyc = TO; exp_err = 1'b1; end
    last_win = w;
    last_wait = 0;
    while (transfer !== 1'b1 && last_wait < 20) begin @(negedge PCLK); last_wait++; end
    total++; if (transfer !== 1'b1) $display("FAIL start: transfer=%b want 1", transfer); else passed++;
    total++; if (gnt !== eg) $display("FAIL gnt: got %b want %b", gnt, eg); else passed++;
    total++; if (READ_WRITE !== erw) $display("FAIL rw: got %b want %b", READ_WRITE, erw); else passed++;
    total++; if (apb_write_paddr !== ea || apb_read_paddr !== ea)
      $display("FAIL paddr: got %h/%h want %h", apb_write_paddr, apb_read_paddr, ea); else passed++;
    total++; if (apb_write_data !== ewd) $display("FAIL wdata: got %h want %h", apb_write_data, ewd); else passed++;
    if (mutate) begin
      if (w == 1) begin rw1 = ~rw1; addr1 = ~addr1; wdata1 = ~wdata1; end
      else begin rw0 = ~rw0; addr0 = ~addr0; wdata0 = ~wdata0; end
      if ($urandom_range(0, 1) == 1) begin if (w == 1) req1 = 1'b0; else req0 = 1'b0; end
    end
    cyc = 0;
    while (transfer === 1'b1 && cyc < 300) begin
      @(negedge PCLK); cyc++;
      if (cyc == 1 && transfer === 1'b1) begin
        total++; if (apb_write_paddr !== ea || READ_WRITE !== erw)
          $display("FAIL held: got %h/%b want %h/%b", apb_write_paddr, READ_WRITE, ea, erw); else passed++;
      end
    end
    if (!exp_err && erw) exp_rdata = rd_data;
    ptr_m = (w == 0);
    total++; if (cyc !== exp_cyc) $display("FAIL xfer_len: got %0d want %0d", cyc, exp_cyc); else passed++;
    total++; if ({ack1, ack0} !== eg) $display("FAIL ack: got %b want %b", {ack1, ack0}, eg); else passed++;
    total++; if (err !== exp_err) $display("FAIL err: got %b want %b", err, exp_err); else passed++;
    total++; if (rdata !== exp_rdata) $display("FAIL rdata: got %h want %h", rdata, exp_rdata); else passed++;
    total++; if (gnt !== 2'b00) $display("FAIL done_gnt: got %b want 00", gnt); else passed++;
    if (drop) begin if (w == 1) req1 = 1'b0; else req0 = 1'b0; end
    @(negedge PCLK);
    total++; if ({ack1, ack0, err, transfer} !== 4'b0000)
      $display("FAIL pulse_width: ack/err/transfer got %b want 0000", {ack1, ack0, err, transfer}); else passed++;
  endtask

  task automatic test_reset;
    PRESETn = 1'b0;
    req0 = 1'b1; rw0 = 1'b0; addr0 = 9'h005; wdata0 = 8'hA5;
    req1 = 1'b0; rw1 = 1'b0; addr1 = 9'h000; wdata1 = 8'h00;
    ws = 0; slv = 1'b0; rd_data = 8'h00;
    repeat (3) @(negedge PCLK);
    total++; if ({gnt, ack1, ack0, err, transfer, READ_WRITE} !== 7'd0)
      $display("FAIL reset_ctl: got %b want 0", {gnt, ack1, ack0, err, transfer, READ_WRITE}); else passed++;
    total++; if ({apb_write_paddr, apb_read_paddr, apb_write_data, rdata} !== 34'd0)
      $display("FAIL reset_data: got %h want 0", {apb_write_paddr, apb_read_paddr, apb_write_data, rdata}); else passed++;
    PRESETn = 1'b1; ptr_m = 1'b0; exp_rdata = 8'h00;
    @(negedge PCLK);
    total++; if (transfer !== 1'b0) $display("FAIL first_edge: transfer=%b want 0", transfer); else passed++;
  endtask

  task automatic test_single_write;
    do_txn(1'b1, 1'b0);
  endtask

  task automatic test_read_slave2;
    req1 = 1'b1; rw1 = 1'b1; addr1 = 9'h10F; wdata1 = 8'h77; rd_data = 8'h3C;
    do_txn(1'b1, 1'b0);
  endtask

  task automatic test_contention;
    PRESETn = 1'b0;
    req0 = 1'b1; rw0 = 1'b0; addr0 = 9'h021; wdata0 = 8'h11;
    req1 = 1'b1; rw1 = 1'b1; addr1 = 9'h1A2; wdata1 = 8'h22; rd_data = 8'h5A;
    @(negedge PCLK);
    PRESETn = 1'b1; ptr_m = 1'b0; exp_rdata = 8'h00;
    for (int k = 0; k < 4; k++) begin
      do_txn(1'b0, 1'b0);
      total++; if (last_win !== (k % 2)) $display("FAIL order: got %0d want %0d", last_win, k % 2); else passed++;
      if (k > 0) begin
        total++; if (last_wait !== 1) $display("FAIL gap: got %0d want 1", last_wait); else passed++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_wait_states;
    req0 = 1'b1; rw0 = 1'b1; addr0 = 9'h044; rd_data = 8'hC3; ws = 5;
    do_txn(1'b1, 1'b0);
    ws = 0;
  endtask

  task automatic test_timeout;
    req1 = 1'b1; rw1 = 1'b1; addr1 = 9'h133; rd_data = 8'hEE; ws = 100;
    do_txn(1'b1, 1'b0);
    ws = 0;
  endtask

  task automatic test_reset_mid_xfer;
    int n;
    req1 = 1'b1; rw1 = 1'b0; addr1 = 9'h1F0; wdata1 = 8'h99; ws = 100;
    n = 0;
    while (transfer !== 1'b1 && n < 20) begin @(negedge PCLK); n++; end
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b0;
    #1;
    total++; if ({gnt, ack1, ack0, err, transfer, READ_WRITE} !== 7'd0)
      $display("FAIL mid_reset_ctl: got %b want 0", {gnt, ack1, ack0, err, transfer, READ_WRITE}); else passed++;
    total++; if ({apb_write_paddr, apb_read_paddr, apb_write_data, rdata} !== 34'd0)
      $display("FAIL mid_reset_data: got %h want 0", {apb_write_paddr, apb_read_paddr, apb_write_data, rdata}); else passed++;
    @(negedge PCLK);
    PRESETn = 1'b1; ptr_m = 1'b0; exp_rdata = 8'h00; ws = 0;
    req0 = 1'b1; rw0 = 1'b0; addr0 = 9'h0AB; wdata0 = 8'h5C;
    @(negedge PCLK);
    total++; if ({transfer, ack1, ack0} !== 3'b000)
      $display("FAIL post_reset: transfer/ack got %b want 000", {transfer, ack1, ack0}); else passed++;
    do_txn(1'b1, 1'b0);
    total++; if (last_win !== 0) $display("FAIL reset_ptr: winner %0d want 0", last_win); else passed++;
    do_txn(1'b1, 1'b0);
  endtask

  task automatic test_random;
    int r;
    for (int it = 0; it < 40; it++) begin
      if (!req0 && $urandom_range(0, 1) == 1) begin
        req0 = 1'b1; rw0 = 1'($urandom_range(0, 1));
        addr0 = 9'($urandom_range(0, 511)); wdata0 = 8'($urandom_range(0, 255));
      end
      if (!req1 && $urandom_range(0, 1) == 1) begin
        req1 = 1'b1; rw1 = 1'($urandom_range(0, 1));
        addr1 = 9'($urandom_range(0, 511)); wdata1 = 8'($urandom_range(0, 255));
      end
      if (!req0 && !req1) begin
        req0 = 1'b1; rw0 = 1'($urandom_range(0, 1));
        addr0 = 9'($urandom_range(0, 511)); wdata0 = 8'($urandom_range(0, 255));
      end
      r = $urandom_range(0, 9);
      if (r < 6) ws = r; else if (r == 6) ws = 12; else if (r == 7) ws = 13; else ws = 30;
      slv = ($urandom_range(0, 7) == 0);
      rd_data = 8'($urandom_range(0, 255));
      do_txn(1'b1, 1'b1);
    end
    req0 = 1'b0; req1 = 1'b0; slv = 1'b0; ws = 0;
  endtask

  initial begin
    passed = 0; total = 0;
    test_reset;
    test_single_write;
    test_read_slave2;
    test_contention;
    test_wait_states;
    test_timeout;
    test_reset_mid_xfer;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT_CYCLES, default 15, the maximum number of XFER cycles without completion (range 2..255).
REQ-002 PCLK  in  1  sole clock; all state SHALL change on its rising edge.
REQ-003 PRESETn  in  1  asynchronous, active-low reset.
REQ-004 req0, req1  in  1 each  transfer request; held high until the matching ack.
REQ-005 rw0, rw1  in  1 each  1 = read, 0 = write.
REQ-006 addr0, addr1  in  9 each  target address; bit 8 selects the slave.
REQ-007 wdata0, wdata1  in  8 each  write data.
REQ-008 gnt  out  2  one-hot current owner (bit0 = requester 0); 00 when idle.
REQ-009 ack0, ack1  out  1 each  one-cycle completion pulse.
REQ-010 err  out  1  qualifies the ack pulse; 1 = slave error or timeout.
REQ-011 rdata  out  8  read data; valid with the ack pulse of a read.
REQ-012 transfer  out  1  bridge transfer request.
REQ-013 READ_WRITE  out  1  bridge direction (1 = read).
REQ-014 apb_write_paddr, apb_read_paddr  out  9 each  bridge addresses.
REQ-015 apb_write_data  out  8  bridge write data.
REQ-016 PENABLE, PREADY, PSLVERR  in  1 each  monitored bridge and bus status.
REQ-017 apb_read_data_out  in  8  read data returned by the bridge.

Function
REQ-018 The FSM SHALL have three states: IDLE, XFER and DONE.
REQ-019 IDLE: if req0 or req1 is high, the block SHALL select a winner, latch its rw/addr/wdata into command registers, set gnt and enter XFER; otherwise it SHALL stay in IDLE.
REQ-020 Arbitration SHALL be round-robin with a 1-bit priority pointer. With both requests high, the pointer's requester wins. After each grant, the pointer SHALL point at the other requester.
REQ-021 The latched address SHALL drive both apb_write_paddr and apb_read_paddr; the latched write data SHALL drive apb_write_data (zero for reads); the latched rw SHALL drive READ_WRITE.
REQ-022 transfer SHALL be 1 exactly while in XFER. Its first high cycle SHALL be the cycle after the request was sampled in IDLE.
REQ-023 XFER, normal completion: when PENABLE and PREADY are both sampled high, the block SHALL register rdata (apb_read_data_out for a read, held value for a write), pulse the winner's ack with err = 0 in the next cycle, and enter DONE.
REQ-024 XFER, slave error: PSLVERR sampled high SHALL take priority over completion. The block SHALL pulse ack with err = 1 and enter DONE; rdata SHALL be unchanged.
REQ-025 XFER, timeout: an 8-bit counter SHALL clear on entry to XFER and increment each XFER cycle. When it reaches TIMEOUT_CYCLES-1 with no completion, the block SHALL pulse ack with err = 1 and enter DONE.
REQ-026 DONE SHALL last exactly one cycle with transfer = 0 and gnt = 00, then return to IDLE. This forces the bridge back to its idle state and enforces at least one dead cycle between transfers.
REQ-027 The ack and err pulses SHALL coincide with the DONE cycle and SHALL be exactly one cycle wide.
REQ-028 Changes to req, rw, addr or wdata during XFER SHALL be ignored; a requester dropping req mid-transfer SHALL still receive its ack.
REQ-029 The loser of a simultaneous request SHALL be granted at the next IDLE evaluation if its request is still high; worst-case wait is one transfer.

Reset
REQ-030 PRESETn low SHALL immediately, asynchronously force: state IDLE, pointer to requester 0, gnt 00, ack0/ack1/err 0, transfer 0, READ_WRITE 0, all addresses and data 0, rdata 0, counter 0.
REQ-031 Reset during XFER SHALL abort the transfer with no ack. The first transfer after reset release SHALL start no earlier than the second rising edge.

Structure
REQ-032 A shared package SHALL hold: the state encoding (IDLE, XFER, DONE as one-hot 3-bit), ADDR_W = 9, DATA_W = 8, and the TIMEOUT_CYCLES default.
REQ-033 The round-robin selector (inputs req[1:0] and pointer; outputs one-hot winner) SHALL be one sub-module, rr_sel2. All other logic SHALL stay in apb_req_arbiter.

Verification
REQ-034 The bench SHALL cover these scenarios:
- Single write: req0, rw0 = 0, addr0 = 0x005, wdata0 = 0xA5, PREADY high on the first PENABLE cycle -> transfer high 3 cycles, apb_write_data = 0xA5, ack0 pulse with err = 0, gnt returns to 00.
- Read from slave 2: req1, rw1 = 1, addr1 = 0x10F, apb_read_data_out = 0x3C -> READ_WRITE = 1, apb_read_paddr = 0x10F, rdata = 0x3C with the ack1 pulse.
- Contention: req0 and req1 both high from reset, held -> grant order 0, 1, 0, 1, with one DONE cycle between each pair.
- Wait states: PREADY low for 5 PENABLE cycles, then high -> single ack, err = 0, no timeout.
- Timeout: PREADY never high, TIMEOUT_CYCLES = 15 -> ack with err = 1 after exactly 15 XFER cycles, then DONE, IDLE, transfer = 0.
- Reset mid-XFER: PRESETn low for 1 cycle during XFER -> all outputs 0 in the same cycle, no ack, next grant goes to requester 0.
